// File: rtl/frame_seq_pkg.sv
// Shared definitions for the frame sequencer: FSM state encoding, screen
// geometry, sprite size and default colours.
package frame_seq_pkg;

  typedef enum logic [2:0] {
    S_INIT_DRAW  = 3'd0,
    S_WAIT_FRAME = 3'd1,
    S_ERASE      = 3'd2,
    S_REQ        = 3'd3,
    S_WAIT_CHG   = 3'd4,
    S_DRAW       = 3'd5
  } state_t;

  localparam int XMAX     = 160;
  localparam int YMAX     = 120;
  localparam int BOX      = 4;
  localparam int PIX_LAST = BOX * BOX - 1;

  localparam logic [2:0] COLOUR_FG_DEFAULT = 3'b111;
  localparam logic [2:0] COLOUR_BG_DEFAULT = 3'b000;

endpackage

// File: rtl/box_addr.sv
// Maps a 4-bit pixel offset inside the 4x4 sprite to a screen coordinate,
// wrapping at the right and bottom screen edges.
// Ports:
//   base_x/base_y : top-left corner of the sprite
//   offset        : pixel index, [1:0] = column, [3:2] = row
//   pix_x/pix_y   : wrapped screen coordinate of that pixel
module box_addr
  import frame_seq_pkg::*;
(
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  input  logic [3:0] offset,
  output logic [7:0] pix_x,
  output logic [6:0] pix_y
);

  // One bit wider than the coordinate so the edge comparison cannot overflow.
  logic [8:0] sum_x;
  logic [7:0] sum_y;

  always_comb begin
    sum_x = {1'b0, base_x} + {7'd0, offset[1:0]};
    sum_y = {1'b0, base_y} + {6'd0, offset[3:2]};
    pix_x = (sum_x >= 9'(XMAX)) ? 8'(sum_x - 9'(XMAX)) : sum_x[7:0];
    pix_y = (sum_y >= 8'(YMAX)) ? 7'(sum_y - 8'(YMAX)) : sum_y[6:0];
  end

endmodule

// File: rtl/frame_sequencer.sv
// Animation sequencer for a 4x4 sprite: waits FRAME_TICKS running cycles,
// erases the sprite, asks the position-update logic for a new position,
// then redraws it.
// Ports:
//   clock, resetn     : clock, synchronous active-low reset
//   run               : animation enable (frame counter only advances when 1)
//   nextx, nexty      : candidate position, valid while change=1
//   change            : one-cycle pulse, accepted only in S_WAIT_CHG
//   enableGL          : one-cycle request for a new position
//   curX, curY        : committed sprite position
//   plot/vga_x/vga_y/colour : pixel-write port
//   frame_done        : one-cycle pulse after each completed redraw
//   timeout_err       : sticky, set when the change pulse never arrived
//   dbg_state         : current FSM state
// Handshake: enableGL is a single-cycle request; the responder answers with
// a single-cycle change pulse carrying nextx/nexty. A pulse outside
// S_WAIT_CHG is dropped; if none arrives in CHG_TIMEOUT cycles the old
// position is kept.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int         FRAME_TICKS = 10000,
  parameter logic [7:0] START_X     = 8'd0,
  parameter logic [6:0] START_Y     = 7'd0,
  parameter logic [2:0] FG_COLOUR   = COLOUR_FG_DEFAULT,
  parameter logic [2:0] BG_COLOUR   = COLOUR_BG_DEFAULT,
  parameter int         CHG_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       run,
  input  logic [7:0] nextx,
  input  logic [6:0] nexty,
  input  logic       change,
  output logic       enableGL,
  output logic [7:0] curX,
  output logic [6:0] curY,
  output logic       plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       frame_done,
  output logic       timeout_err,
  output state_t     dbg_state
);

  localparam int WW = $clog2(CHG_TIMEOUT + 1);

  state_t        state, state_next;
  logic [19:0]   frame_cnt;
  logic [3:0]    pix_cnt;
  logic [WW-1:0] wait_cnt;
  logic [7:0]    cur_x;
  logic [6:0]    cur_y;
  logic          armed;
  logic          done_q;
  logic          err_q;
  logic [7:0]    addr_x;
  logic [6:0]    addr_y;

  logic pix_state, pix_active, pix_last, frame_hit, chg_take, chg_expire;

  // The first cycle after reset is spent idle in S_INIT_DRAW (armed=0) so
  // that the cycle following a reset edge never plots.
  assign pix_state  = (state == S_INIT_DRAW) || (state == S_ERASE) || (state == S_DRAW);
  assign pix_active = pix_state && ((state != S_INIT_DRAW) || armed);
  assign pix_last   = pix_active && (pix_cnt == 4'(PIX_LAST));
  assign frame_hit  = (state == S_WAIT_FRAME) && run && (frame_cnt == 20'(FRAME_TICKS - 1));
  assign chg_take   = (state == S_WAIT_CHG) && change;
  // A change in the final wait cycle wins over the timeout.
  assign chg_expire = (state == S_WAIT_CHG) && !change && (wait_cnt == WW'(CHG_TIMEOUT - 1));

  box_addr u_box_addr (
    .base_x (cur_x),
    .base_y (cur_y),
    .offset (pix_cnt),
    .pix_x  (addr_x),
    .pix_y  (addr_y)
  );

  always_ff @(posedge clock) begin
    if (!resetn) state <= S_INIT_DRAW;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_INIT_DRAW:  if (pix_last)             state_next = S_WAIT_FRAME;
      S_WAIT_FRAME: if (frame_hit)            state_next = S_ERASE;
      S_ERASE:      if (pix_last)             state_next = S_REQ;
      S_REQ:                                  state_next = S_WAIT_CHG;
      S_WAIT_CHG:   if (chg_take || chg_expire) state_next = S_DRAW;
      S_DRAW:       if (pix_last)             state_next = S_WAIT_FRAME;
      default:                                state_next = S_INIT_DRAW;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      frame_cnt <= '0;
      pix_cnt   <= '0;
      wait_cnt  <= '0;
      cur_x     <= START_X;
      cur_y     <= START_Y;
      armed     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      armed  <= 1'b1;
      done_q <= (state == S_DRAW) && pix_last;

      // Wraps 15 -> 0 on the last pixel, ready for the next sequence.
      if (pix_active) pix_cnt <= pix_cnt + 4'd1;
      else            pix_cnt <= '0;

      if (state != S_WAIT_FRAME) frame_cnt <= '0;
      else if (frame_hit)        frame_cnt <= '0;
      else if (run)              frame_cnt <= frame_cnt + 20'd1;

      if (state == S_WAIT_CHG) wait_cnt <= wait_cnt + WW'(1);
      else                     wait_cnt <= '0;

      if (chg_take) begin
        cur_x <= nextx;
        cur_y <= nexty;
      end
      if (chg_expire) err_q <= 1'b1;
    end
  end

  assign plot        = pix_active;
  assign vga_x       = pix_active ? addr_x : 8'd0;
  assign vga_y       = pix_active ? addr_y : 7'd0;
  assign colour      = !pix_active ? 3'b000 : ((state == S_ERASE) ? BG_COLOUR : FG_COLOUR);
  assign enableGL    = (state == S_REQ);
  assign curX        = cur_x;
  assign curY        = cur_y;
  assign frame_done  = done_q;
  assign timeout_err = err_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;
  import frame_seq_pkg::*;

  localparam int         FT = 8;
  localparam int         CT = 15;
  localparam logic [7:0] SX = 8'd0;
  localparam logic [6:0] SY = 7'd0;
  localparam int         FG = 7;
  localparam int         BG = 0;

  // ---------------- clock / reset / DUT ----------------
  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       run = 1'b0;
  logic       change = 1'b0;
  logic [7:0] nextx = 8'd0;
  logic [6:0] nexty = 7'd0;
  logic       enableGL, plot, frame_done, timeout_err;
  logic [7:0] curX, vga_x;
  logic [6:0] curY, vga_y;
  logic [2:0] colour;
  state_t     dbg_state;

  always #5 clock = ~clock;

  frame_sequencer #(
    .FRAME_TICKS (FT),
    .START_X     (SX),
    .START_Y     (SY),
    .FG_COLOUR   (3'b111),
    .BG_COLOUR   (3'b000),
    .CHG_TIMEOUT (CT)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .run         (run),
    .nextx       (nextx),
    .nexty       (nexty),
    .change      (change),
    .enableGL    (enableGL),
    .curX        (curX),
    .curY        (curY),
    .plot        (plot),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .colour      (colour),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q[$];
  logic [17:0] seen_q[$];
  bit mon_en = 1'b0;

  // Reference model: sprite position and sticky error.
  int mx, my;
  bit merr;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_pix(input logic [17:0] act, input logic [17:0] req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL pixel actual=(%0d,%0d,c%0d) required=(%0d,%0d,c%0d)",
               act[17:10], act[9:3], act[2:0], req[17:10], req[9:3], req[2:0]);
    end
  endtask

  function automatic logic [17:0] pix(input int x, input int y, input int c);
    return {8'(x), 7'(y), 3'(c)};
  endfunction

  // Expected 4x4 sprite, raster order, wrapped with plain modulo arithmetic.
  task automatic push_box(input int bx, input int by, input int c);
    for (int k = 0; k < 16; k++)
      exp_q.push_back(pix((bx + k % 4) % 160, (by + k / 4) % 120, c));
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (plot) begin
        seen_q.push_back({vga_x, vga_y, colour});
        if (exp_q.size() == 0) check("unexpected_plot", 1, 0);
        else check_pix({vga_x, vga_y, colour}, exp_q.pop_front());
      end else begin
        check("idle_port", int'({vga_x, vga_y, colour}), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Runs until the plot burst of an INIT_DRAW ends; returns on the first
  // WAIT_FRAME cycle.
  task automatic wait_init();
    int cnt;
    bit seen;
    cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (plot) begin
        cnt++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
    end
    check("init_plot_count", cnt, 16);
  endtask

  // One animation step, entered on WAIT_FRAME cycle 0, returns on the
  // frame_done cycle (the next WAIT_FRAME cycle 0). n = WAIT_CHG cycles
  // until change (0 = never).
  task automatic do_step(input int n, input int nx, input int ny, input int p_start,
                         input int p_len, input bit stray, output int lat);
    int c_req, wchg, c_done, new_x, new_y, en_cnt, en_at;
    bit new_err;
    c_req   = FT + p_len + 16;
    wchg    = (n > 0) ? n : CT;
    c_done  = c_req + 1 + wchg + 16;
    new_x   = (n > 0) ? nx : mx;
    new_y   = (n > 0) ? ny : my;
    new_err = merr || (n == 0);
    push_box(mx, my, BG);
    push_box(new_x, new_y, FG);
    en_cnt = 0;
    en_at  = -1;
    lat    = -1;
    for (int c = 0; c < 300; c++) begin
      if (enableGL) begin
        en_cnt++;
        if (en_at < 0) en_at = c;
      end
      if (frame_done && c > 0) begin
        lat = c;
        break;
      end
      run    = !(p_len > 0 && c >= p_start && c < p_start + p_len);
      change = 1'b0;
      nextx  = 8'($urandom_range(0, 159));
      nexty  = 7'($urandom_range(0, 119));
      if (stray && (c == 2 || c == c_req)) change = 1'b1;
      if (n > 0 && c == c_req + n) begin
        change = 1'b1;
        nextx  = 8'(nx);
        nexty  = 7'(ny);
      end
      @(negedge clock);
    end
    change = 1'b0;
    check("enable_count", en_cnt, 1);
    check("enable_cycle", en_at, c_req);
    check("step_latency", lat, c_done);
    check("curX", int'(curX), new_x);
    check("curY", int'(curY), new_y);
    check("timeout_err", int'(timeout_err), int'(new_err));
    mx   = new_x;
    my   = new_y;
    merr = new_err;
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    int n;
    int nx;
    int ny;
    int p_start;
    int p_len;
    bit stray;
    int exp_x;
    int exp_y;
    int exp_err;
    int exp_lat;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int lat, found, oob;

    tbl[0] = '{3, 10, 20, 0, 0, 1'b0, 10, 20, 0, 44};    // change 3 cycles after enableGL
    tbl[1] = '{1, 158, 118, 0, 0, 1'b1, 158, 118, 0, 42}; // stray pulses ignored
    tbl[2] = '{15, 5, 7, 0, 0, 1'b0, 5, 7, 0, 56};       // wrapped erase, change on last wait cycle
    tbl[3] = '{2, 40, 50, 3, 5, 1'b0, 40, 50, 0, 48};    // run=0 for 5 cycles
    tbl[4] = '{0, 99, 99, 0, 0, 1'b1, 40, 50, 1, 56};    // change never returned

    // Reset state
    resetn = 1'b0;
    run    = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_plot", int'(plot), 0);
    check("rst_enableGL", int'(enableGL), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
    check("rst_curX", int'(curX), int'(SX));
    check("rst_curY", int'(curY), int'(SY));
    mx = SX;
    my = SY;
    merr = 1'b0;
    push_box(mx, my, FG);
    resetn = 1'b1;
    wait_init();

    // Directed table
    for (int i = 0; i < 5; i++) begin
      if (i == 2) seen_q.delete();
      do_step(tbl[i].n, tbl[i].nx, tbl[i].ny, tbl[i].p_start, tbl[i].p_len, tbl[i].stray, lat);
      check("tbl_curX", int'(curX), tbl[i].exp_x);
      check("tbl_curY", int'(curY), tbl[i].exp_y);
      check("tbl_err", int'(timeout_err), tbl[i].exp_err);
      check("tbl_latency", lat, tbl[i].exp_lat);
      if (i == 2) begin
        found = 0;
        foreach (seen_q[j]) if (seen_q[j] == pix(0, 118, BG)) found = 1;
        check("wrap_0_118", found, 1);
        found = 0;
        foreach (seen_q[j]) if (seen_q[j] == pix(159, 119, BG)) found = 1;
        check("wrap_159_119", found, 1);
        found = 0;
        foreach (seen_q[j]) if (seen_q[j] == pix(1, 1, BG)) found = 1;
        check("wrap_1_1", found, 1);
        oob = 0;
        foreach (seen_q[j]) if (seen_q[j][17:10] >= 160 || seen_q[j][9:3] >= 120) oob++;
        check("wrap_in_range", oob, 0);
      end
    end

    // Randomised steps against the model
    for (int i = 0; i < 8; i++) begin
      do_step($urandom_range(0, 15), $urandom_range(0, 159), $urandom_range(0, 119),
              $urandom_range(0, FT - 1), $urandom_range(0, 4), 1'($urandom_range(0, 1)), lat);
    end

    // Reset in the middle of ERASE (pixel 7)
    push_box(mx, my, BG);
    run = 1'b1;
    change = 1'b0;
    for (int c = 0; c < FT + 7; c++) @(negedge clock);
    check("erase_px7_plot", int'(plot), 1);
    check("erase_px7_colour", int'(colour), BG);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    exp_q.delete();
    check("abort_plot", int'(plot), 0);
    check("abort_curX", int'(curX), int'(SX));
    check("abort_curY", int'(curY), int'(SY));
    check("abort_err", int'(timeout_err), 0);
    check("abort_enableGL", int'(enableGL), 0);
    mx = SX;
    my = SY;
    merr = 1'b0;
    push_box(mx, my, FG);
    wait_init();
    do_step(4, 77, 33, 0, 0, 1'b0, lat);
    check("post_abort_latency", lat, FT + 16 + 1 + 4 + 16);

    repeat (2) @(negedge clock);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter FRAME_TICKS, 10000, clock cycles between animation steps while run=1.
REQ-002 Parameter START_X, 0, reset X position (0..159); START_Y, 0, reset Y position (0..119).
REQ-003 Parameter FG_COLOUR, 3'b111, sprite colour; BG_COLOUR, 3'b000, erase colour.
REQ-004 Parameter CHG_TIMEOUT, 15, maximum wait cycles for the change pulse.
REQ-005 clock  in  1  system clock; resetn  in  1  reset, synchronous, active-low.
REQ-006 run  in  1  animation enable; 0 freezes the frame counter.
REQ-007 nextx  in  8, nexty  in  7  candidate position from the position-update logic.
REQ-008 change  in  1  one-cycle pulse: nextx/nexty valid.
REQ-009 enableGL  out  1  one-cycle request to the position-update logic.
REQ-010 curX  out  8, curY  out  7  committed sprite position.
REQ-011 plot  out  1, vga_x  out  8, vga_y  out  7, colour  out  3  pixel-write port.
REQ-012 frame_done  out  1  one-cycle pulse per completed step; timeout_err  out  1  sticky flag.

Function
REQ-013 FSM states: INIT_DRAW, WAIT_FRAME, ERASE, REQ, WAIT_CHG, DRAW; all outputs are Moore outputs of registered state and counters.
REQ-014 After reset, the FSM enters INIT_DRAW and draws the 4x4 sprite at START_X/START_Y, then goes to WAIT_FRAME.
REQ-015 WAIT_FRAME: a 20-bit counter increments only while run=1. At count FRAME_TICKS-1 the counter clears and the FSM goes to ERASE. When run=0 the count holds.
REQ-016 ERASE/DRAW/INIT_DRAW: plot=1 for exactly 16 consecutive cycles, with a 4-bit offset counter running 0..15.
  - Pixel k: vga_x = curX + k[1:0], vga_y = curY + k[3:2].
  - colour = BG_COLOUR in ERASE, FG_COLOUR otherwise.
REQ-017 Wrap-around: if curX+dx >= 160, vga_x = curX+dx-160; if curY+dy >= 120, vga_y = curY+dy-120. Sums are computed 1 bit wider.
REQ-018 Outside pixel states: plot=0, vga_x=0, vga_y=0, colour=0.
REQ-019 REQ lasts one cycle with enableGL=1, then goes to WAIT_CHG (enableGL=0).
REQ-020 WAIT_CHG: on change=1, curX<=nextx and curY<=nexty, then go to DRAW.
REQ-021 WAIT_CHG: if CHG_TIMEOUT cycles elapse without change, curX/curY are held, timeout_err<=1, then go to DRAW.
REQ-022 change is ignored in every state except WAIT_CHG.
REQ-023 change and timeout expiry in the same cycle: change wins; no error is flagged.
REQ-024 frame_done=1 for the single cycle after the last DRAW pixel, coincident with re-entry to WAIT_FRAME. INIT_DRAW does not raise frame_done.
REQ-025 run is sampled only in WAIT_FRAME; a pixel sequence in progress always completes.
REQ-026 Step latency with change returned after n cycles: FRAME_TICKS + 16 + 1 + n + 16 cycles from WAIT_FRAME entry to frame_done.

Reset
REQ-027 On resetn=0 at a clock edge, in any state including mid-ERASE/DRAW:
  - state=INIT_DRAW; all counters=0; curX=START_X, curY=START_Y;
  - plot, enableGL, frame_done, timeout_err, vga_x, vga_y, colour all 0.
REQ-028 An aborted erase or draw is not resumed; the sprite redraws at the start position.

Structure
REQ-029 Shared package frame_seq_pkg holds the state encoding, XMAX=160, YMAX=120, BOX=4 and the colour constants.
REQ-030 One sub-module, box_addr (combinational offset-to-wrapped-coordinate), is instantiated once and shared by ERASE, DRAW and INIT_DRAW.

Verification
REQ-031 Reset, FRAME_TICKS=8 -> 16 plot cycles at (0..3,0..3) colour 7, then no further plot until 8 run cycles have elapsed.
REQ-032 curX=158, curY=118, erase -> pixels include (0,118), (159,119), (1,1); no coordinate >= 160/120.
REQ-033 change=1 with nextx=10, nexty=20, three cycles after enableGL -> curX=10, curY=20, DRAW at (10..13,20..23), frame_done one cycle later.
REQ-034 change never returned -> after 15 WAIT_CHG cycles timeout_err=1 and redraw at the old position; change pulse during WAIT_FRAME -> position unchanged.
REQ-035 run=0 midway through WAIT_FRAME for 5 cycles -> step delayed by exactly 5 cycles; resetn=0 at ERASE pixel 7 -> next cycle plot=0, curX=START_X, then INIT_DRAW.
